// File: rtl/sync_handshake_tx.sv
// Source-side controller for a toggle-handshake multi-bit clock-domain crossing.
// Optional ack watchdog enabled by defining SYNC_HANDSHAKE_TX_TIMEOUT_EN.
module sync_handshake_tx #(
  parameter int unsigned Width         = 8,
  parameter int unsigned Stages        = 2,
  parameter int unsigned InitValue     = 0,
  parameter int unsigned TimeoutCycles = 1024
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [Width-1:0] in_data,
  output logic [Width-1:0] xfer_data,
  output logic             xfer_req,
  input  logic             xfer_ack_async,
  output logic             busy,
  output logic             timeout,
  input  logic             timeout_clr
);

  localparam logic [Width-1:0] InitData = Width'(InitValue);
  localparam int unsigned      AlignW   = $clog2(Stages + 1);
  localparam logic [AlignW-1:0] AlignLast = AlignW'(Stages);

  if (Stages < 2) begin : g_bad_stages
    $error("sync_handshake_tx: Stages must be >= 2");
  end

  typedef enum logic [1:0] {
    ALIGN    = 2'd0,
    IDLE     = 2'd1,
    WAIT_ACK = 2'd2
  } state_e;

  state_e             state_q;
  logic               req_q;
  logic [Width-1:0]   data_q;
  logic [AlignW-1:0]  align_cnt_q;
  logic [Stages-1:0]  ack_sync_q;
  logic               ack_s;

  always_ff @(posedge clk) begin
    if (reset) begin
      ack_sync_q <= '0;
    end else begin
      ack_sync_q <= {ack_sync_q[Stages-2:0], xfer_ack_async};
    end
  end

  assign ack_s = ack_sync_q[Stages-1];

  // ALIGN first lets the freshly reset synchronizer fill before trusting ack_s,
  // so an ack left high across reset is seen and blocks new accepts.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ALIGN;
      req_q       <= 1'b0;
      data_q      <= InitData;
      align_cnt_q <= '0;
    end else begin
      case (state_q)
        ALIGN: begin
          if (align_cnt_q != AlignLast) begin
            align_cnt_q <= align_cnt_q + AlignW'(1);
          end else if (ack_s == req_q) begin
            state_q <= IDLE;
          end
        end
        IDLE: begin
          if (in_valid) begin
            data_q  <= in_data;
            req_q   <= ~req_q;
            state_q <= WAIT_ACK;
          end
        end
        WAIT_ACK: begin
          if (ack_s == req_q) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q     <= ALIGN;
          align_cnt_q <= '0;
        end
      endcase
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign xfer_req  = req_q;
  assign xfer_data = data_q;

`ifdef SYNC_HANDSHAKE_TX_TIMEOUT_EN
  localparam int unsigned   CntW    = $clog2(TimeoutCycles + 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(TimeoutCycles);
  localparam logic [CntW-1:0] CntPrev = CntW'(TimeoutCycles - 1);

  logic [CntW-1:0] cnt_q;
  logic            timeout_q;
  logic            expire;

  assign expire = (state_q == WAIT_ACK) && (cnt_q == CntPrev);

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      if (state_q == IDLE && in_valid) begin
        cnt_q <= '0;
      end else if (state_q == WAIT_ACK && cnt_q != CntMax) begin
        cnt_q <= cnt_q + CntW'(1);
      end
      if (expire) begin
        timeout_q <= 1'b1;
      end else if (timeout_clr) begin
        timeout_q <= 1'b0;
      end
    end
  end

  assign timeout = timeout_q;
`else
  logic unused_timeout_clr;
  assign unused_timeout_clr = timeout_clr;
  assign timeout            = 1'b0;
`endif

endmodule

// File: tb/tb_sync_handshake_tx.sv
// Directed self-checking bench for sync_handshake_tx (Stages=2, InitValue=8'h5A).
// Define SYNC_HANDSHAKE_TX_TIMEOUT_EN to also exercise the watchdog.
module tb_sync_handshake_tx;

  localparam logic [7:0] INIT = 8'h5A;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic [7:0] xfer_data;
  logic       xfer_req;
  logic       xfer_ack_async;
  logic       busy;
  logic       timeout;
  logic       timeout_clr;

  int n_tests = 0;
  int n_fail  = 0;

  sync_handshake_tx #(
    .Width(8),
    .Stages(2),
    .InitValue(32'h5A),
    .TimeoutCycles(16)
  ) dut (
    .clk(clk),
    .reset(reset),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .xfer_data(xfer_data),
    .xfer_req(xfer_req),
    .xfer_ack_async(xfer_ack_async),
    .busy(busy),
    .timeout(timeout),
    .timeout_clr(timeout_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [7:0] d;
    logic       ack;
    logic       rdy;
    logic       req;
    logic [7:0] xd;
    logic       bsy;
  } vec_t;

  vec_t tbl[18];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; in_valid = 1'b0; in_data = '0; xfer_ack_async = 1'b0; timeout_clr = 1'b0;
    repeat (3) step();
    check("rst_ready", in_ready, 0);
    check("rst_busy", busy, 1);
    check("rst_req", xfer_req, 0);
    check("rst_data", xfer_data, INIT);
    check("rst_timeout", timeout, 0);
    reset = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    logic [7:0] words [3];
    logic [2:0] hist;
    logic       prev_req, acc, done, seen, exp_to;
    logic [7:0] held;
    int         idx, tog, cyc;

    //            v     d      ack   rdy   req   xd     bsy
    tbl[0]  = '{1'b1, 8'hEE, 1'b0, 1'b0, 1'b0, INIT,  1'b1};
    tbl[1]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, INIT,  1'b1};
    tbl[2]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, INIT,  1'b0};
    tbl[3]  = '{1'b1, 8'hA5, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b1};
    tbl[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b1};
    tbl[5]  = '{1'b1, 8'h77, 1'b0, 1'b0, 1'b1, 8'hA5, 1'b1};
    tbl[6]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b1};
    tbl[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hA5, 1'b1};
    tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA5, 1'b0};
    tbl[9]  = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0};
    tbl[10] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 8'hA5, 1'b0};
    tbl[11] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA5, 1'b0};
    tbl[12] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA5, 1'b0};
    tbl[13] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA5, 1'b0};
    tbl[14] = '{1'b1, 8'h3C, 1'b1, 1'b0, 1'b0, 8'h3C, 1'b1};
    tbl[15] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b1};
    tbl[16] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b1};
    tbl[17] = '{1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h3C, 1'b0};

    do_reset();
    for (int i = 0; i < 18; i++) begin
      in_valid = tbl[i].v; in_data = tbl[i].d; xfer_ack_async = tbl[i].ack;
      step();
      check($sformatf("vec%0d_ready", i), in_ready, tbl[i].rdy);
      check($sformatf("vec%0d_req", i), xfer_req, tbl[i].req);
      check($sformatf("vec%0d_data", i), xfer_data, tbl[i].xd);
      check($sformatf("vec%0d_busy", i), busy, tbl[i].bsy);
      check($sformatf("vec%0d_timeout", i), timeout, 0);
    end

    // Back-to-back words with a remote that echoes xfer_req three cycles later.
    words[0] = 8'h01; words[1] = 8'h02; words[2] = 8'h03;
    hist = '0; idx = 0; tog = 0; done = 1'b0;
    prev_req = xfer_req; held = xfer_data;
    for (int c = 0; c < 80 && !done; c++) begin
      in_valid = (idx < 3);
      in_data  = (idx < 3) ? words[idx] : 8'h00;
      xfer_ack_async = hist[2];
      hist = {hist[1:0], xfer_req};
      acc = in_ready && in_valid;
      step();
      if (acc) idx++;
      if (xfer_req !== prev_req) begin
        tog++;
        if (tog <= 3) check("b2b_word", xfer_data, words[tog-1]);
        held = xfer_data; prev_req = xfer_req;
      end else if (busy) begin
        check("b2b_hold", xfer_data, held);
      end
      if (tog == 3 && in_ready) done = 1'b1;
    end
    in_valid = 1'b0;
    check("b2b_toggles", tog, 3);
    check("b2b_accepts", idx, 3);
    check("b2b_done", done, 1);

    // Reset in WAIT_ACK while the remote ack sits high.
    do_reset();
    repeat (3) step();
    check("mid_ready_pre", in_ready, 1);
    in_valid = 1'b1; in_data = 8'h11;
    step();
    check("mid_req_set", xfer_req, 1);
    in_valid = 1'b0; xfer_ack_async = 1'b1;
    step();
    reset = 1'b1;
    step();
    check("mid_rst_req", xfer_req, 0);
    check("mid_rst_ready", in_ready, 0);
    reset = 1'b0; in_valid = 1'b1; in_data = 8'h22;
    for (int k = 0; k < 6; k++) begin
      step();
      check("mid_align_ready", in_ready, 0);
      check("mid_align_req", xfer_req, 0);
      check("mid_align_data", xfer_data, INIT);
    end
    in_valid = 1'b0; xfer_ack_async = 1'b0;
    cyc = 0; seen = 1'b0;
    for (int k = 0; k < 8 && !seen; k++) begin
      step();
      cyc++;
      if (in_ready) seen = 1'b1;
    end
    check("mid_release_seen", seen, 1);
    check("mid_release_cycles", cyc, 3);

    // Transfer with no ack for a while; watchdog flags it only when built in.
    in_valid = 1'b1; in_data = 8'h42;
    step();
    in_valid = 1'b0;
    for (int k = 1; k <= 18; k++) begin
      timeout_clr = (k == 16 || k == 17);
`ifdef SYNC_HANDSHAKE_TX_TIMEOUT_EN
      exp_to = (k == 16);
`else
      exp_to = 1'b0;
`endif
      step();
      check($sformatf("to_cyc%0d", k), timeout, exp_to);
      check("to_busy", busy, 1);
    end
    timeout_clr = 1'b0;
    xfer_ack_async = 1'b1;
    cyc = 0; seen = 1'b0;
    for (int k = 0; k < 8 && !seen; k++) begin
      step();
      cyc++;
      if (in_ready) seen = 1'b1;
    end
    check("to_complete", seen, 1);
    check("to_complete_cycles", cyc, 3);
    check("to_data_held", xfer_data, 8'h42);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
